// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if: start/status, ROM read port and output stream of the ROM stream reader
interface rom_stream_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  modport master (
    input  start, base_addr, length, rom_q, out_ready,
    output busy, done, rom_addr, out_data, out_valid
  );
  modport slave (
    output start, base_addr, length, rom_q, out_ready,
    input  busy, done, rom_addr, out_data, out_valid
  );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: fetches length words from a pipelined ROM and streams them on valid/ready,
// issuing reads only when the output FIFO has a guaranteed slot for the returning word
module rom_stream_reader #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic clock,
  input logic reset,
  rom_stream_reader_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RL = READ_LATENCY;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d, iss_q, iss_d, acc_q, acc_d;
  logic [RL:0]           vld_q, vld_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q, cnt_d, infl;
  logic                  issue, cap, pop, credit;
  assign bus.busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.done      = state_q == DONE;
  assign bus.rom_addr  = addr_q;
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_data  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  // vld_q bit k marks a read whose address went out k cycles ago; the top bit lines up with rom_q
  always_comb begin
    infl = '0;
    for (int k = 0; k <= RL; k++) infl = infl + CW'(vld_q[k]);
    pop    = (cnt_q != '0) && bus.out_ready;
    cap    = vld_q[RL];
    // a word popped this cycle frees its slot in time for a read issued now
    credit = (CW+1)'(infl) + (CW+1)'(cnt_q) < (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
    issue  = (state_q == IDLE) ? bus.start && (bus.length != '0)
                               : (state_q == FETCH) && (iss_q < len_q) && credit;
    len_d  = (state_q == IDLE && bus.start) ? bus.length : len_q;
    iss_d  = ((state_q == IDLE) ? '0 : iss_q) + (ADDR_WIDTH+1)'(issue);
    acc_d  = ((state_q == IDLE) ? '0 : acc_q) + (ADDR_WIDTH+1)'(pop);
    addr_d = issue ? ((state_q == IDLE) ? bus.base_addr : addr_q + 1'b1) : addr_q;
    vld_d  = {vld_q[RL-1:0], issue};
    cnt_d  = cnt_q + CW'(cap) - CW'(pop);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.length == '0) ? DONE : FETCH;
      FETCH:   if (iss_d == len_q) state_d = DRAIN;
      DRAIN:   if (acc_d == len_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      acc_q   <= '0;
      vld_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      wr_q    <= wr_q + PW'(cap);
      rd_q    <= rd_q + PW'(pop);
      cnt_q   <= cnt_d;
      if (cap) mem_q[wr_q] <= bus.rom_q;
    end
  end
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: directed table and sequence checks of rom_stream_reader with a q=addr*3 ROM model
module tb_rom_stream_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  rom_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) b0 ();
  rom_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) b1 ();
  rom_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) b4 ();
  rom_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(2), .FIFO_DEPTH(4))
    u0 (.clock(clk), .reset(rst), .bus(b0.master));
  rom_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(1), .FIFO_DEPTH(4))
    u1 (.clock(clk), .reset(rst), .bus(b1.master));
  rom_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(4), .FIFO_DEPTH(8))
    u4 (.clock(clk), .reset(rst), .bus(b4.master));
  logic [15:0] p0 [2];
  logic [15:0] p1;
  logic [15:0] p4 [4];
  always_ff @(posedge clk) begin
    p0[0] <= 16'(b0.rom_addr) * 16'd3;
    p0[1] <= p0[0];
    p1    <= 16'(b1.rom_addr) * 16'd3;
    p4[0] <= 16'(b4.rom_addr) * 16'd3;
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
  end
  assign b0.rom_q = p0[1];
  assign b1.rom_q = p1;
  assign b4.rom_q = p4[3];
  typedef struct {
    bit          st;
    logic [7:0]  base;
    logic [8:0]  len;
    bit          rdy;
    bit          busy;
    bit          done;
    bit          valid;
    logic [15:0] data;
    bit          ca;
    logic [7:0]  addr;
  } vec_t;
  vec_t vt [24];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    // base 0, len 4: words 0,3,6,9 in cycles 4..7, done in cycle 8
    vt[0]  = '{1'b1, 8'd0,   9'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,   1'b0, 8'd0};
    vt[1]  = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 8'd0};
    vt[2]  = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 8'd1};
    vt[3]  = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 8'd2};
    vt[4]  = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0,   1'b1, 8'd3};
    vt[5]  = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3,   1'b1, 8'd3};
    vt[6]  = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd6,   1'b1, 8'd3};
    vt[7]  = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd9,   1'b1, 8'd3};
    vt[8]  = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0,   1'b1, 8'd3};
    vt[9]  = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,   1'b0, 8'd0};
    // base 254, len 4: address wrap 254,255,0,1
    vt[10] = '{1'b1, 8'd254, 9'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,   1'b0, 8'd0};
    vt[11] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 8'd254};
    vt[12] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 8'd255};
    vt[13] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 8'd0};
    vt[14] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd762, 1'b1, 8'd1};
    vt[15] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd765, 1'b1, 8'd1};
    vt[16] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0,   1'b1, 8'd1};
    vt[17] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3,   1'b1, 8'd1};
    vt[18] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0,   1'b1, 8'd1};
    vt[19] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,   1'b0, 8'd0};
    // len 0 goes straight to done; a start during done is ignored
    vt[20] = '{1'b1, 8'd5,   9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,   1'b1, 8'd1};
    vt[21] = '{1'b1, 8'd0,   9'd4, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0,   1'b1, 8'd1};
    vt[22] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,   1'b1, 8'd1};
    vt[23] = '{1'b0, 8'd0,   9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,   1'b1, 8'd1};
    b0.start = 0; b0.base_addr = '0; b0.length = '0; b0.out_ready = 1;
    b1.start = 0; b1.base_addr = '0; b1.length = '0; b1.out_ready = 1;
    b4.start = 0; b4.base_addr = '0; b4.length = '0; b4.out_ready = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_done", int'(b0.done), 0);
    chk("rst_valid", int'(b0.out_valid), 0);
    chk("rst_data", int'(b0.out_data), 0);
    chk("rst_addr", int'(b0.rom_addr), 0);
    tick();
    rst = 0;
    for (int i = 0; i < 24; i++) begin
      b0.start = vt[i].st; b0.base_addr = vt[i].base; b0.length = vt[i].len; b0.out_ready = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), int'(b0.busy), int'(vt[i].busy));
      chk($sformatf("v%0d_done", i), int'(b0.done), int'(vt[i].done));
      chk($sformatf("v%0d_valid", i), int'(b0.out_valid), int'(vt[i].valid));
      if (vt[i].valid) chk($sformatf("v%0d_data", i), int'(b0.out_data), int'(vt[i].data));
      if (vt[i].ca) chk($sformatf("v%0d_addr", i), int'(b0.rom_addr), int'(vt[i].addr));
      tick();
    end
    b0.start = 0;
    // back-pressure: toggling ready with a 10-cycle hold
    begin
      int got = 0, maxo = 0, unstable = 0, o;
      bit prev_stall = 0, saw_done = 0;
      logic [15:0] prev_d = '0;
      b0.base_addr = 8'd10; b0.length = 9'd8; b0.start = 1;
      tick();
      b0.start = 0;
      for (int j = 1; j < 200 && !saw_done; j++) begin
        b0.out_ready = (j >= 6 && j < 16) ? 1'b0 : j[0];
        @(negedge clk);
        if (prev_stall && (!b0.out_valid || b0.out_data != prev_d)) unstable++;
        if (b0.busy) begin
          o = int'(8'(b0.rom_addr - 8'd10)) + 1 - got;
          if (o > maxo) maxo = o;
        end
        if (b0.out_valid && b0.out_ready) begin
          chk($sformatf("bp_word%0d", got), int'(b0.out_data), (10 + got) * 3);
          got++;
        end
        if (b0.done) saw_done = 1;
        prev_stall = b0.out_valid && !b0.out_ready;
        prev_d = b0.out_data;
        tick();
      end
      chk("bp_count", got, 8);
      chk("bp_done", int'(saw_done), 1);
      chk("bp_credits", maxo, 4);
      chk("bp_stable", unstable, 0);
    end
    // ignored restart, then reset at the third word
    b0.out_ready = 1; b0.base_addr = 8'd0; b0.length = 9'd8; b0.start = 1;
    tick();
    for (int c = 1; c <= 6; c++) begin
      b0.start = (c == 2); b0.base_addr = (c == 2) ? 8'd100 : 8'd0; b0.length = (c == 2) ? 9'd2 : 9'd8;
      @(negedge clk);
      if (c >= 4) begin
        chk($sformatf("rs_valid%0d", c), int'(b0.out_valid), 1);
        chk($sformatf("rs_data%0d", c), int'(b0.out_data), (c - 4) * 3);
      end
      if (c == 6) rst = 1;
      tick();
    end
    b0.start = 0;
    @(negedge clk);
    chk("ab_busy", int'(b0.busy), 0);
    chk("ab_done", int'(b0.done), 0);
    chk("ab_valid", int'(b0.out_valid), 0);
    chk("ab_data", int'(b0.out_data), 0);
    chk("ab_addr", int'(b0.rom_addr), 0);
    tick();
    rst = 0;
    begin
      int stray = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (b0.done || b0.out_valid || b0.busy) stray++;
        tick();
      end
      chk("ab_quiet", stray, 0);
    end
    b0.base_addr = 8'd20; b0.length = 9'd3; b0.start = 1;
    tick();
    b0.start = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("nb_valid%0d", c), int'(b0.out_valid), int'(c >= 4 && c <= 6));
      if (c >= 4 && c <= 6) chk($sformatf("nb_data%0d", c), int'(b0.out_data), 60 + (c - 4) * 3);
      chk($sformatf("nb_done%0d", c), int'(b0.done), int'(c == 7));
      tick();
    end
    // latency 1 and 4 builds, 16 words each
    begin
      int f1 = -1, f4 = -1, n1 = 0, n4 = 0, bad1 = 0, bad4 = 0;
      b1.base_addr = 8'd40; b1.length = 9'd16; b1.start = 1;
      b4.base_addr = 8'd40; b4.length = 9'd16; b4.start = 1;
      tick();
      b1.start = 0; b4.start = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (b1.out_valid) begin
          if (f1 < 0) f1 = c;
          if (c != f1 + n1 || int'(b1.out_data) != 120 + 3 * n1) bad1++;
          n1++;
        end
        if (b4.out_valid) begin
          if (f4 < 0) f4 = c;
          if (c != f4 + n4 || int'(b4.out_data) != 120 + 3 * n4) bad4++;
          n4++;
        end
        tick();
      end
      chk("rl1_first", f1, 3);
      chk("rl4_first", f4, 6);
      chk("rl1_count", n1, 16);
      chk("rl4_count", n4, 16);
      chk("rl1_stream", bad1, 0);
      chk("rl4_stream", bad4, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
